// File: rtl/regfile_write_arbiter_if.sv
// Write-back request/grant bundle between the control FSM sources and the
// register-file write arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              flush;
  logic [3:0]        Req;
  logic [3:0]        Ready;
  logic [DATA_W-1:0] AluData;
  logic [ADDR_W-1:0] AluRd;
  logic [DATA_W-1:0] LoadData;
  logic [ADDR_W-1:0] LoadRt;
  logic [DATA_W-1:0] LinkData;
  logic [DATA_W-1:0] SpData;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [2:0]        RegDest;
  logic              WritePending;

  // Request side: the write-back sources and control FSM
  modport master (
    output flush, Req, AluData, AluRd, LoadData, LoadRt, LinkData, SpData,
    input  Ready, RegWrite, WriteReg, WriteData, RegDest, WritePending
  );

  // Arbiter side: drives the register-file write port
  modport slave (
    input  flush, Req, AluData, AluRd, LoadData, LoadRt, LinkData, SpData,
    output Ready, RegWrite, WriteReg, WriteData, RegDest, WritePending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: one buffered request slot per write-back
// source (ALU, load, JAL link, stack pointer), round-robin grant, registered
// write port plus RegDest select code.
// Optional feature: define REGWR_ZERO_DROP_EN to silently retire writes to $0.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned SP_REG   = 29
) (
  input logic                   clk,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned NSRC   = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CODE_W = 3;

  localparam logic [CODE_W-1:0] CODE_RT   = 3'b000;
  localparam logic [CODE_W-1:0] CODE_RD   = 3'b001;
  localparam logic [CODE_W-1:0] CODE_LINK = 3'b010;
  localparam logic [CODE_W-1:0] CODE_SP   = 3'b011;

  typedef enum logic {IDLE, ARB} state_t;

  state_t            state;
  logic [NSRC-1:0]   pending;
  logic [PTR_W-1:0]  rr_ptr;
  logic [DATA_W-1:0] slot_data [NSRC];
  logic [ADDR_W-1:0] slot_dest [NSRC];
  logic [CODE_W-1:0] slot_code [NSRC];

  logic              reg_write_q;
  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic [CODE_W-1:0] reg_dest_q;
  logic              write_pending_q;

  logic [DATA_W-1:0] src_data [NSRC];
  logic [ADDR_W-1:0] src_dest [NSRC];
  logic [CODE_W-1:0] src_code [NSRC];

  logic [NSRC-1:0]   capture_c;
  logic [NSRC-1:0]   grant_oh_c;
  logic [NSRC-1:0]   pending_nxt_c;
  logic              grant_vld_c;
  logic [PTR_W-1:0]  grant_idx_c;
  logic [PTR_W-1:0]  cand_c;
  logic              drop_c;
  logic              write_c;

  // Per-source payload: link and sp have fixed destinations
  always_comb begin
    src_data[0] = bus.AluData;
    src_dest[0] = bus.AluRd;
    src_code[0] = CODE_RD;
    src_data[1] = bus.LoadData;
    src_dest[1] = bus.LoadRt;
    src_code[1] = CODE_RT;
    src_data[2] = bus.LinkData;
    src_dest[2] = ADDR_W'(LINK_REG);
    src_code[2] = CODE_LINK;
    src_data[3] = bus.SpData;
    src_dest[3] = ADDR_W'(SP_REG);
    src_code[3] = CODE_SP;
  end

  // Round-robin search starting one past the last granted slot
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = rr_ptr;
    cand_c      = rr_ptr;
    for (int unsigned k = 1; k <= NSRC; k++) begin
      cand_c = rr_ptr + PTR_W'(k);
      if (!grant_vld_c && pending[cand_c]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = cand_c;
      end
    end
    if (state != ARB || bus.flush) begin
      grant_vld_c = 1'b0;
    end
  end

`ifdef REGWR_ZERO_DROP_EN
  assign drop_c = (slot_dest[grant_idx_c] == '0);
`else
  assign drop_c = 1'b0;
`endif

  // Slot bookkeeping for the coming edge; flush discards everything
  always_comb begin
    grant_oh_c    = grant_vld_c ? (NSRC'(1) << grant_idx_c) : '0;
    capture_c     = bus.flush ? '0 : (bus.Req & ~pending);
    pending_nxt_c = bus.flush ? '0 : ((pending & ~grant_oh_c) | capture_c);
    write_c       = grant_vld_c & ~drop_c;
  end

  // FSM, slot storage, round-robin pointer and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pending         <= '0;
      rr_ptr          <= PTR_W'(NSRC - 1);
      reg_write_q     <= 1'b0;
      write_reg_q     <= '0;
      write_data_q    <= '0;
      reg_dest_q      <= '0;
      write_pending_q <= 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
        slot_data[i] <= '0;
        slot_dest[i] <= '0;
        slot_code[i] <= '0;
      end
    end else begin
      pending         <= pending_nxt_c;
      reg_write_q     <= write_c;
      write_pending_q <= (|pending_nxt_c) | write_c;
      if (grant_vld_c) begin
        rr_ptr <= grant_idx_c;
      end
      if (write_c) begin
        write_reg_q  <= slot_dest[grant_idx_c];
        write_data_q <= slot_data[grant_idx_c];
        reg_dest_q   <= slot_code[grant_idx_c];
      end
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (capture_c[i]) begin
          slot_data[i] <= src_data[i];
          slot_dest[i] <= src_dest[i];
          slot_code[i] <= src_code[i];
        end
      end
      case (state)
        IDLE: if (|capture_c) state <= ARB;
        ARB:  if (bus.flush || !(|pending_nxt_c)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Ready        = ~pending;
  assign bus.RegWrite     = reg_write_q;
  assign bus.WriteReg     = write_reg_q;
  assign bus.WriteData    = write_data_q;
  assign bus.RegDest      = reg_dest_q;
  assign bus.WritePending = write_pending_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-cycle vector table plus a
// hand-written saturated round-robin sequence.
module tb_regfile_write_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NV     = 30;

  localparam logic [31:0] ALU_D = 32'hDEAD_BEEF;
  localparam logic [31:0] LD_D  = 32'h1111_2222;
  localparam logic [31:0] LNK_D = 32'h0040_0008;
  localparam logic [31:0] SP_D  = 32'h0000_7FFC;

  logic clk = 1'b0;
  logic reset;

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(31), .SP_REG(29)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [3:0]  req;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [2:0]  rdest;
    logic [3:0]  ready;
    logic        wp;
  } vec_t;

  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input logic rst, input logic flush, input logic [3:0] req,
                             input logic [4:0] rd, input logic [4:0] rt,
                             input logic rw, input logic [4:0] wreg, input logic [31:0] wdata,
                             input logic [2:0] rdest, input logic [3:0] ready, input logic wp);
    vec_t r;
    r.rst = rst; r.flush = flush; r.req = req; r.rd = rd; r.rt = rt;
    r.rw = rw; r.wreg = wreg; r.wdata = wdata; r.rdest = rdest; r.ready = ready; r.wp = wp;
    return r;
  endfunction

  task automatic check_outs(input string name, input logic rw, input logic [4:0] wreg,
                            input logic [31:0] wdata, input logic [2:0] rdest,
                            input logic [3:0] ready, input logic wp);
    checks++;
    if ({bus.RegWrite, bus.WriteReg, bus.WriteData, bus.RegDest, bus.Ready, bus.WritePending}
        !== {rw, wreg, wdata, rdest, ready, wp}) begin
      errors++;
      $display("FAIL %s: got rw=%b wreg=%0d wdata=%h rdest=%b ready=%b wp=%b, want rw=%b wreg=%0d wdata=%h rdest=%b ready=%b wp=%b",
               name, bus.RegWrite, bus.WriteReg, bus.WriteData, bus.RegDest, bus.Ready,
               bus.WritePending, rw, wreg, wdata, rdest, ready, wp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] rr_wreg [4];
    int n;

    // single ALU write, latency 2 edges
    vecs[0]  = v(0, 0, 4'b0001, 5, 8, 0,  0, 32'h0, 3'b000, 4'b1110, 1);
    vecs[1]  = v(0, 0, 4'b0000, 5, 8, 1,  5, ALU_D, 3'b001, 4'b1111, 1);
    vecs[2]  = v(0, 0, 4'b0000, 5, 8, 0,  5, ALU_D, 3'b001, 4'b1111, 0);
    // reset beats requests, then all four in one cycle
    vecs[3]  = v(1, 1, 4'b1111, 5, 8, 0,  0, 32'h0, 3'b000, 4'b1111, 0);
    vecs[4]  = v(0, 0, 4'b1111, 5, 8, 0,  0, 32'h0, 3'b000, 4'b0000, 1);
    vecs[5]  = v(0, 0, 4'b0000, 5, 8, 1,  5, ALU_D, 3'b001, 4'b0001, 1);
    vecs[6]  = v(0, 0, 4'b0000, 5, 8, 1,  8, LD_D,  3'b000, 4'b0011, 1);
    vecs[7]  = v(0, 0, 4'b0000, 5, 8, 1, 31, LNK_D, 3'b010, 4'b0111, 1);
    vecs[8]  = v(0, 0, 4'b0000, 5, 8, 1, 29, SP_D,  3'b011, 4'b1111, 1);
    vecs[9]  = v(0, 0, 4'b0000, 5, 8, 0, 29, SP_D,  3'b011, 4'b1111, 0);
    // slot 0 re-requested as soon as it frees; slot 2 still served second
    vecs[10] = v(0, 0, 4'b0101, 5, 8, 0, 29, SP_D,  3'b011, 4'b1010, 1);
    vecs[11] = v(0, 0, 4'b0000, 5, 8, 1,  5, ALU_D, 3'b001, 4'b1011, 1);
    vecs[12] = v(0, 0, 4'b0001, 5, 8, 1, 31, LNK_D, 3'b010, 4'b1110, 1);
    vecs[13] = v(0, 0, 4'b0000, 5, 8, 1,  5, ALU_D, 3'b001, 4'b1111, 1);
    vecs[14] = v(0, 0, 4'b0000, 5, 8, 0,  5, ALU_D, 3'b001, 4'b1111, 0);
    // request held across its own grant edge is taken one edge later
    vecs[15] = v(0, 0, 4'b0001, 5, 8, 0,  5, ALU_D, 3'b001, 4'b1110, 1);
    vecs[16] = v(0, 0, 4'b0001, 5, 8, 1,  5, ALU_D, 3'b001, 4'b1111, 1);
    vecs[17] = v(0, 0, 4'b0001, 5, 8, 0,  5, ALU_D, 3'b001, 4'b1110, 1);
    vecs[18] = v(0, 0, 4'b0000, 5, 8, 1,  5, ALU_D, 3'b001, 4'b1111, 1);
    vecs[19] = v(0, 0, 4'b0000, 5, 8, 0,  5, ALU_D, 3'b001, 4'b1111, 0);
    // flush at first grant edge; flush-cycle request ignored
    vecs[20] = v(0, 0, 4'b0011, 5, 8, 0,  5, ALU_D, 3'b001, 4'b1100, 1);
    vecs[21] = v(0, 1, 4'b0100, 5, 8, 0,  5, ALU_D, 3'b001, 4'b1111, 0);
    vecs[22] = v(0, 0, 4'b0000, 5, 8, 0,  5, ALU_D, 3'b001, 4'b1111, 0);
    // pointer kept across flush: load wins; flush after an in-flight write
    vecs[23] = v(0, 0, 4'b0011, 5, 8, 0,  5, ALU_D, 3'b001, 4'b1100, 1);
    vecs[24] = v(0, 0, 4'b0000, 5, 8, 1,  8, LD_D,  3'b000, 4'b1110, 1);
    vecs[25] = v(0, 1, 4'b0000, 5, 8, 0,  8, LD_D,  3'b000, 4'b1111, 0);
    vecs[26] = v(0, 0, 4'b0000, 5, 8, 0,  8, LD_D,  3'b000, 4'b1111, 0);
    // write to $0
    vecs[27] = v(0, 0, 4'b0001, 0, 8, 0,  8, LD_D,  3'b000, 4'b1110, 1);
`ifdef REGWR_ZERO_DROP_EN
    vecs[28] = v(0, 0, 4'b0000, 0, 8, 0,  8, LD_D,  3'b000, 4'b1111, 0);
    vecs[29] = v(0, 0, 4'b0000, 0, 8, 0,  8, LD_D,  3'b000, 4'b1111, 0);
`else
    vecs[28] = v(0, 0, 4'b0000, 0, 8, 1,  0, ALU_D, 3'b001, 4'b1111, 1);
    vecs[29] = v(0, 0, 4'b0000, 0, 8, 0,  0, ALU_D, 3'b001, 4'b1111, 0);
`endif

    reset        = 1'b1;
    bus.flush    = 1'b0;
    bus.Req      = 4'b0000;
    bus.AluData  = ALU_D;
    bus.AluRd    = 5'd5;
    bus.LoadData = LD_D;
    bus.LoadRt   = 5'd8;
    bus.LinkData = LNK_D;
    bus.SpData   = SP_D;

    tick();
    tick();
    check_outs("reset", 1'b0, 5'd0, 32'h0, 3'b000, 4'b1111, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < int'(NV); i++) begin
      reset     = vecs[i].rst;
      bus.flush = vecs[i].flush;
      bus.Req   = vecs[i].req;
      bus.AluRd = vecs[i].rd;
      bus.LoadRt = vecs[i].rt;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].rw, vecs[i].wreg, vecs[i].wdata,
                 vecs[i].rdest, vecs[i].ready, vecs[i].wp);
    end

    // saturated requests from reset: first write after 2 edges, then one per cycle
    reset     = 1'b1;
    bus.flush = 1'b0;
    bus.Req   = 4'b0000;
    bus.AluRd = 5'd5;
    bus.LoadRt = 5'd8;
    tick();
    reset   = 1'b0;
    bus.Req = 4'b1111;
    n = 0;
    while (!bus.RegWrite && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.RegWrite || n != 2) begin
      errors++;
      $display("FAIL sat_latency: got rw=%b after %0d edges, want rw=1 after 2 edges",
               bus.RegWrite, n);
    end
    rr_wreg[0] = 5'd5;
    rr_wreg[1] = 5'd8;
    rr_wreg[2] = 5'd31;
    rr_wreg[3] = 5'd29;
    for (int k = 1; k < 12; k++) begin
      tick();
      checks++;
      if (bus.RegWrite !== 1'b1 || bus.WriteReg !== rr_wreg[k % 4]) begin
        errors++;
        $display("FAIL sat_rr%0d: got rw=%b wreg=%0d, want rw=1 wreg=%0d",
                 k, bus.RegWrite, bus.WriteReg, rr_wreg[k % 4]);
      end
    end
    bus.Req = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
